uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle done pulse and stores it in a circular buffer.
- Presents stored bytes to the consumer (CPU/bus bridge) through a first-word-fall-through valid/ready interface.
- Flags bytes lost to overflow with a sticky error bit.

Parameters:
- DATA_W, 8, width of a stored byte; matches the receiver data output.
- DEPTH_LOG2, 4, log2 of buffer depth (default 16 entries). Legal range 1..8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_data_i  input  DATA_W  received byte; connects to the receiver data output.
- wr_en_i  input  1  one-cycle write strobe; connects to the receiver done pulse.
- rd_data_o  output  DATA_W  byte at the head of the buffer; valid only while rd_valid_o=1.
- rd_valid_o  output  1  high when the buffer holds at least one byte.
- rd_ready_i  input  1  consumer accepts the head byte when high with rd_valid_o.
- full_o  output  1  count == 2**DEPTH_LOG2.
- empty_o  output  1  count == 0; always equals ~rd_valid_o.
- ovf_o  output  1  sticky overflow flag.
- ovf_clr_i  input  1  one-cycle clear of ovf_o.

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - Write pointer, read pointer and count are 0; ovf_o=0.
  - empty_o=1, full_o=0, rd_valid_o=0.
  - Memory contents are not reset; rd_data_o is don't-care while rd_valid_o=0.
- Pointers are DEPTH_LOG2+1 bits wide. The MSB is a wrap bit, and the address is the low DEPTH_LOG2 bits.
  - Wrap from 2**DEPTH_LOG2-1 to 0 is natural binary roll-over.
  - Full when the addresses are equal and the wrap bits differ. Empty when the pointers are equal.
- Push: wr_en_i=1 and (not full, or pop in the same cycle).
  - mem[wr_addr] <= wr_data_i; wr_ptr increments.
- Pop: rd_valid_o=1 and rd_ready_i=1; rd_ptr increments.
- rd_data_o = mem[rd_addr], a combinational read. Latency:
  - A byte pushed at edge N is visible with rd_valid_o=1 immediately after edge N.
  - After a pop at edge N, the next byte (if any) is presented after edge N.
- Count: +1 on push only, -1 on pop only, unchanged on push+pop or idle.
  - full_o and empty_o are derived from the registered pointers, with no extra cycle of lag.
- Simultaneous push and pop when full: both are performed, count stays at max, no overflow.
- Simultaneous push when empty: no pop is possible (rd_valid_o=0); count goes to 1.
- Overflow: wr_en_i=1, full, and no pop in the same cycle.
  - The byte is discarded; pointers and memory are unchanged; ovf_o <= 1.
- ovf_o stays high until ovf_clr_i=1. If set and clear occur in the same cycle, set wins (ovf_o stays 1).
- wr_en_i held high for multiple cycles is treated as one push per cycle; no edge detection.
- rd_ready_i while empty has no effect.
- Reset mid-operation discards all buffered bytes and ovf state immediately.
- No state machine beyond the pointer/count registers; all outputs except rd_data_o are registered or derived only from registers.

Optional Feature:
- Macro: UART_RX_FIFO_LEVEL_EN.
- When defined:
  - Adds output port level_o, width DEPTH_LOG2+1, equal to the current count (0..2**DEPTH_LOG2), updated on the same edge as the pointers.
  - Adds output port half_full_o = (count >= 2**(DEPTH_LOG2-1)), for interrupt generation.
- When undefined: neither port exists, and no level or half-full logic is synthesised. Core behaviour is identical.

Test Plan (DEPTH_LOG2=2, depth 4, unless noted):
- Reset, then push 0xA5 for one cycle -> after that edge rd_valid_o=1, rd_data_o=0xA5, empty_o=0. Pop -> empty_o=1 next cycle.
- Push 0x11, 0x22, 0x33, 0x44 with rd_ready_i=0 -> full_o=1. Then pop four -> data order 0x11, 0x22, 0x33, 0x44, then empty_o=1.
- Fill to full, push 0x55 with no pop -> 0x55 dropped, ovf_o=1; head byte still 0x11, count 4. Pulse ovf_clr_i -> ovf_o=0.
- Fill to full, push 0x66 with pop in the same cycle -> no overflow, full_o stays 1, popped 0x11, and 0x66 is read last.
- Push and pop continuously for 10 bytes (0x00..0x09) with rd_ready_i=1 -> pointers wrap twice, and the output sequence matches the input exactly.
- Assert rst with 3 bytes buffered and ovf_o=1 -> same cycle empty_o=1, ovf_o=0. With UART_RX_FIFO_LEVEL_EN defined, level_o=0 and half_full_o toggles 0->1 at count 2.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer placed after a UART receiver.
// Each byte arrives with the receiver's one-cycle done pulse and is stored in
// a circular buffer. Bytes leave through a first-word-fall-through
// valid/ready interface. A sticky flag records bytes dropped on overflow.
// Optional feature macro: UART_RX_FIFO_LEVEL_EN adds the level_o and
// half_full_o outputs.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              ovf_o,
    input  logic              ovf_clr_i
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                half_full_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  ovf_set;
    logic                  ovf;

    // Decode status from the registered pointers and qualify the push/pop strobes.
    always_comb begin
        wr_addr = wr_ptr[DEPTH_LOG2-1:0];
        rd_addr = rd_ptr[DEPTH_LOG2-1:0];
        // Equal addresses with different wrap bits mean the buffer has gone all the way round.
        full    = (wr_addr == rd_addr) && (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
        empty   = (wr_ptr == rd_ptr);
        pop     = !empty && rd_ready_i;
        // A pop in the same cycle frees a slot, so a full buffer can still accept the byte.
        push    = wr_en_i && (!full || pop);
        ovf_set = wr_en_i && full && !pop;
    end

    // Advance the read and write pointers; binary roll-over provides the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples its inputs as they were before the clock edge.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Store the incoming byte at the write address.
    // NOTE: the storage array has no reset. Contents behind an empty buffer are
    // never observed, and leaving out the reset allows the array to map onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_addr] <= wr_data_i;
    end

    // Sticky overflow flag: a new overflow takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            ovf <= 1'b0;
        else if (ovf_set)   ovf <= 1'b1;
        else if (ovf_clr_i) ovf <= 1'b0;
    end

    assign rd_data_o  = mem[rd_addr];
    assign rd_valid_o = !empty;
    assign empty_o    = empty;
    assign full_o     = full;
    assign ovf_o      = ovf;

`ifdef UART_RX_FIFO_LEVEL_EN
    localparam logic [PTR_W-1:0] HALF = PTR_W'(DEPTH / 2);

    logic [PTR_W-1:0] count;

    // Occupancy counter, updated on the same edge as the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + PTR_W'(1);
                2'b01:   count <= count - PTR_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign level_o     = count;
    assign half_full_o = (count >= HALF);
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed, table-driven bench for uart_rx_fifo with a depth of 4.
// When UART_RX_FIFO_LEVEL_EN is defined, the bench also checks level_o and half_full_o.
module tb_uart_rx_fifo;

    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 2;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] wr_data_i;
    logic              wr_en_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic              rd_ready_i;
    logic              full_o;
    logic              empty_o;
    logic              ovf_o;
    logic              ovf_clr_i;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0] level_o;
    logic                half_full_o;
`endif

    uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data_i  (wr_data_i),
        .wr_en_i    (wr_en_i),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
`ifdef UART_RX_FIFO_LEVEL_EN
        ,
        .level_o    (level_o),
        .half_full_o(half_full_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_empty;
        logic       e_ovf;
        int         e_level;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic wr, input logic [7:0] data, input logic rdy,
                               input logic clr, input logic e_valid, input logic [7:0] e_data,
                               input logic e_full, input logic e_ovf, input int e_level);
        vec_t r;
        r.wr = wr; r.data = data; r.rdy = rdy; r.clr = clr;
        r.e_valid = e_valid; r.e_data = e_data; r.e_full = e_full;
        r.e_empty = !e_valid; r.e_ovf = e_ovf; r.e_level = e_level;
        return r;
    endfunction

    // Drive one cycle of inputs, then let the clock edge happen and settle.
    task automatic cycle(input logic wr, input logic [7:0] data, input logic rdy, input logic clr);
        wr_en_i = wr; wr_data_i = data; rd_ready_i = rdy; ovf_clr_i = clr;
        @(posedge clk);
        #1;
        wr_en_i = 1'b0; rd_ready_i = 1'b0; ovf_clr_i = 1'b0;
    endtask

    task automatic check_level(input string name, input int exp_level);
`ifdef UART_RX_FIFO_LEVEL_EN
        check({name, ".level"}, 32'(level_o), 32'(exp_level));
        check({name, ".half"}, 32'(half_full_o), 32'(exp_level >= 2));
`else
        if (name.len() < 0 || exp_level < 0) $display("unreachable");
`endif
    endtask

    initial begin
        rst = 1'b1; wr_en_i = 1'b0; wr_data_i = '0; rd_ready_i = 1'b0; ovf_clr_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.empty", 32'(empty_o), 32'd1);
        check("reset.valid", 32'(rd_valid_o), 32'd0);
        check("reset.full", 32'(full_o), 32'd0);
        check("reset.ovf", 32'(ovf_o), 32'd0);
        check_level("reset", 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //                wr  data   rdy  clr  valid edata  full ovf lvl
        vecs.push_back(v(1, 8'hA5, 0, 0, 1, 8'hA5, 0, 0, 1)); // single byte falls through
        vecs.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0)); // pop -> empty
        vecs.push_back(v(1, 8'h11, 0, 0, 1, 8'h11, 0, 0, 1));
        vecs.push_back(v(1, 8'h22, 0, 0, 1, 8'h11, 0, 0, 2));
        vecs.push_back(v(1, 8'h33, 0, 0, 1, 8'h11, 0, 0, 3));
        vecs.push_back(v(1, 8'h44, 0, 0, 1, 8'h11, 1, 0, 4)); // full
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h22, 0, 0, 3));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h33, 0, 0, 2));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h44, 0, 0, 1));
        vecs.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0)); // ready while empty: no effect
        vecs.push_back(v(1, 8'h11, 0, 0, 1, 8'h11, 0, 0, 1));
        vecs.push_back(v(1, 8'h22, 0, 0, 1, 8'h11, 0, 0, 2));
        vecs.push_back(v(1, 8'h33, 0, 0, 1, 8'h11, 0, 0, 3));
        vecs.push_back(v(1, 8'h44, 0, 0, 1, 8'h11, 1, 0, 4));
        vecs.push_back(v(1, 8'h55, 0, 0, 1, 8'h11, 1, 1, 4)); // overflow, 0x55 dropped
        vecs.push_back(v(1, 8'h77, 0, 1, 1, 8'h11, 1, 1, 4)); // set and clear together: set wins
        vecs.push_back(v(0, 8'h00, 0, 1, 1, 8'h11, 1, 0, 4)); // clear
        vecs.push_back(v(1, 8'h66, 1, 0, 1, 8'h22, 1, 0, 4)); // push+pop while full
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h33, 0, 0, 3));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h44, 0, 0, 2));
        vecs.push_back(v(0, 8'h00, 1, 0, 1, 8'h66, 0, 0, 1)); // 0x66 comes out last
        vecs.push_back(v(0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));

        foreach (vecs[i]) begin
            cycle(vecs[i].wr, vecs[i].data, vecs[i].rdy, vecs[i].clr);
            check($sformatf("vec%0d.valid", i), 32'(rd_valid_o), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d.empty", i), 32'(empty_o), 32'(vecs[i].e_empty));
            check($sformatf("vec%0d.full", i), 32'(full_o), 32'(vecs[i].e_full));
            check($sformatf("vec%0d.ovf", i), 32'(ovf_o), 32'(vecs[i].e_ovf));
            if (vecs[i].e_valid)
                check($sformatf("vec%0d.data", i), 32'(rd_data_o), 32'(vecs[i].e_data));
            check_level($sformatf("vec%0d", i), vecs[i].e_level);
        end

        // Stream 10 bytes with push and pop every cycle; the pointers wrap more than once.
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 8'(k), 1'b1, 1'b0);
            check($sformatf("stream%0d.valid", k), 32'(rd_valid_o), 32'd1);
            check($sformatf("stream%0d.data", k), 32'(rd_data_o), 32'(k));
            check($sformatf("stream%0d.full", k), 32'(full_o), 32'd0);
            check_level($sformatf("stream%0d", k), 1);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_end.empty", 32'(empty_o), 32'd1);

        // Build a state with 3 buffered bytes and ovf set, then reset asynchronously.
        for (int k = 0; k < 4; k++) cycle(1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
        cycle(1'b1, 8'h88, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("pre_rst.ovf", 32'(ovf_o), 32'd1);
        check("pre_rst.data", 32'(rd_data_o), 32'hC1);
        check_level("pre_rst", 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst.empty", 32'(empty_o), 32'd1);
        check("async_rst.valid", 32'(rd_valid_o), 32'd0);
        check("async_rst.ovf", 32'(ovf_o), 32'd0);
        check("async_rst.full", 32'(full_o), 32'd0);
        check_level("async_rst", 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // After reset the buffer restarts cleanly; half-full rises at a count of 2.
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        check("post_rst1.data", 32'(rd_data_o), 32'h5A);
        check_level("post_rst1", 1);
        cycle(1'b1, 8'h5B, 1'b0, 1'b0);
        check("post_rst2.data", 32'(rd_data_o), 32'h5A);
        check("post_rst2.full", 32'(full_o), 32'd0);
        check_level("post_rst2", 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
